// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: front-panel buttons, counter snapshot and edit/commit outputs
interface time_set_ctrl_if;
  logic        butt_increase;
  logic        butt_decrease;
  logic        butt_change;
  logic        sw_mode;
  logic [23:0] cur_time;
  logic [31:0] cur_date;
  logic        set_active;
  logic        load_time;
  logic        load_date;
  logic [23:0] new_time;
  logic [31:0] new_date;
  logic [7:0]  blink_mask;
  modport slave (
    input  butt_increase, butt_decrease, butt_change, sw_mode, cur_time, cur_date,
    output set_active, load_time, load_date, new_time, new_date, blink_mask
  );
  modport master (
    output butt_increase, butt_decrease, butt_change, sw_mode, cur_time, cur_date,
    input  set_active, load_time, load_date, new_time, new_date, blink_mask
  );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounced front-panel editor producing BCD time/date reload strobes and blink mask
module time_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DB_W            = 20,
  parameter int BLINK_CYCLES    = 12_500_000,
  parameter int BLINK_W         = 24
) (
  input logic            clk,
  input logic            rst,
  time_set_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, E_HOUR, E_MIN, E_SEC, E_DAY, E_MONTH, E_YEAR, COMMIT} state_t;
  state_t              state_q, state_d;
  logic [2:0]          s1_q, s2_q, lvl_q, lvl_d, press_q, press_d;
  logic [DB_W-1:0]     cnt_q [3];
  logic [DB_W-1:0]     cnt_d [3];
  logic [23:0]         t_q, t_d;
  logic [31:0]         d_q, d_d;
  logic                date_q, date_d, mode_q;
  logic [BLINK_W-1:0]  bc_q, bc_d;
  logic                ph_q, ph_d;
  logic                inc, dec, chg, step, abort, entry, wrap;
  logic [7:0]          lim, field;

  function automatic logic [7:0] step2(logic [7:0] v, logic u, logic [7:0] lo, logic [7:0] hi);
    if (u) return v == hi ? lo : v[3:0] == 4'h9 ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
    return v == lo ? hi : v[3:0] == 4'h0 ? {v[7:4] - 4'h1, 4'h9} : v - 8'h01;
  endfunction

  function automatic logic [15:0] step_year(logic [15:0] y, logic u);
    logic [15:0] r;
    logic        c;
    r = y;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) r[4*i+:4] = u ? (y[4*i+:4] == 4'h9 ? 4'h0 : y[4*i+:4] + 4'h1)
                           : (y[4*i+:4] == 4'h0 ? 4'h9 : y[4*i+:4] - 4'h1);
      c = c & (u ? y[4*i+:4] == 4'h9 : y[4*i+:4] == 4'h0);
    end
    return r;
  endfunction

  // BCD divisible-by-4: (10*tens + ones) mod 4 == (2*tens + ones) mod 4
  function automatic logic div4(logic [7:0] b);
    return (b[1:0] + {b[4], 1'b0}) == 2'b00;
  endfunction

  function automatic logic [7:0] dmax(logic [7:0] m, logic [15:0] y);
    logic leap;
    leap = y[7:0] == 8'h00 ? div4(y[15:8]) : div4(y[7:0]);
    return m == 8'h02 ? (leap ? 8'h29 : 8'h28) :
           (m == 8'h04 || m == 8'h06 || m == 8'h09 || m == 8'h11) ? 8'h30 : 8'h31;
  endfunction

  assign {inc, dec, chg} = press_q;
  assign step  = inc ^ dec;
  assign abort = state_q != IDLE && bus.sw_mode != mode_q;
  assign wrap  = bc_q == BLINK_W'(BLINK_CYCLES - 1);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = s2_q[i] == lvl_q[i] ? '0 : cnt_q[i] + DB_W'(1);
      lvl_d[i] = cnt_d[i] == DB_W'(DEBOUNCE_CYCLES) ? s2_q[i] : lvl_q[i];
      cnt_d[i] = lvl_d[i] != lvl_q[i] ? '0 : cnt_d[i];
    end
    press_d = lvl_q & ~lvl_d;
    state_d = state_q;
    t_d     = t_q;
    d_d     = d_q;
    date_d  = date_q;
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (chg) begin
        t_d     = bus.cur_time;
        d_d     = bus.cur_date;
        date_d  = bus.sw_mode;
        state_d = bus.sw_mode ? E_DAY : E_HOUR;
      end
      E_HOUR:  if (chg) state_d = E_MIN;   else if (step) t_d[23:16] = step2(t_q[23:16], inc, 8'h00, 8'h23);
      E_MIN:   if (chg) state_d = E_SEC;   else if (step) t_d[15:8]  = step2(t_q[15:8], inc, 8'h00, 8'h59);
      E_SEC:   if (chg) state_d = COMMIT;  else if (step) t_d[7:0]   = step2(t_q[7:0], inc, 8'h00, 8'h59);
      E_DAY:   if (chg) state_d = E_MONTH; else if (step) d_d[31:24] = step2(d_q[31:24], inc, 8'h01, dmax(d_q[23:16], d_q[15:0]));
      E_MONTH: if (chg) state_d = E_YEAR;  else if (step) d_d[23:16] = step2(d_q[23:16], inc, 8'h01, 8'h12);
      E_YEAR:  if (chg) state_d = COMMIT;  else if (step) d_d[15:0]  = step_year(d_q[15:0], inc);
      default: state_d = IDLE;
    endcase
    lim = dmax(d_d[23:16], d_d[15:0]);
    if ((state_q == E_MONTH || state_q == E_YEAR) && d_d[31:24] > lim) d_d[31:24] = lim;
    entry = state_d != state_q && state_d inside {E_HOUR, E_MIN, E_SEC, E_DAY, E_MONTH, E_YEAR};
    bc_d  = entry ? '0 : state_q == IDLE ? bc_q : wrap ? '0 : bc_q + BLINK_W'(1);
    ph_d  = entry ? 1'b1 : (state_q != IDLE && wrap) ? ~ph_q : ph_q;
  end

  assign field = (state_q == E_HOUR || state_q == E_DAY)  ? 8'hC0 :
                 (state_q == E_MIN  || state_q == E_MONTH) ? 8'h30 :
                 state_q == E_SEC ? 8'h0C : state_q == E_YEAR ? 8'h0F : 8'h00;
  assign bus.set_active = state_q != IDLE;
  assign bus.load_time  = state_q == COMMIT && !date_q && !abort;
  assign bus.load_date  = state_q == COMMIT && date_q && !abort;
  assign bus.new_time   = t_q;
  assign bus.new_date   = d_q;
  assign bus.blink_mask = field & {8{ph_q}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s1_q    <= '1;
      s2_q    <= '1;
      lvl_q   <= '1;
      press_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      t_q     <= '0;
      d_q     <= '0;
      date_q  <= 1'b0;
      mode_q  <= 1'b0;
      bc_q    <= '0;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= {bus.butt_increase, bus.butt_decrease, bus.butt_change};
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      t_q     <= t_d;
      d_q     <= d_d;
      date_q  <= date_d;
      mode_q  <= bus.sw_mode;
      bc_q    <= bc_d;
      ph_q    <= ph_d;
    end
  end
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed and random button sequences checked against a calendar-arithmetic model
module tb_time_set_ctrl;
  localparam int DB = 4;
  localparam int BL = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  time_set_ctrl_if bus();
  time_set_ctrl #(.DEBOUNCE_CYCLES(DB), .DB_W(20), .BLINK_CYCLES(BL), .BLINK_W(24)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, nlt = 0, nld = 0, exp_lt = 0, exp_ld = 0;
  logic [23:0] lt_val = '0, exp_tv = '0;
  logic [31:0] ld_val = '0, exp_dv = '0;
  int mf = 0;
  bit mode = 1'b0;
  int hh = 0, mi = 0, ss = 0, dd = 0, mo = 0, yy = 0;
  int c_hh, c_mi, c_ss, c_dd, c_mo, c_yy;

  always @(negedge clk) begin
    if (bus.load_time) begin nlt++; lt_val = bus.new_time; end
    if (bus.load_date) begin nld++; ld_val = bus.new_date; end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit leap(int y);
    return y % 4 == 0 && (y % 100 != 0 || y % 400 == 0);
  endfunction
  function automatic int mdays(int m, int y);
    return m == 2 ? (leap(y) ? 29 : 28) : (m == 4 || m == 6 || m == 9 || m == 11) ? 30 : 31;
  endfunction
  function automatic logic [7:0] b2(int v);
    return 8'((v / 10) * 16 + v % 10);
  endfunction
  function automatic logic [23:0] enc_t(int h, int m, int s);
    return {b2(h), b2(m), b2(s)};
  endfunction
  function automatic logic [31:0] enc_d(int d, int m, int y);
    return {b2(d), b2(m), b2(y / 100), b2(y % 100)};
  endfunction

  task automatic set_cur(input int h, input int m, input int s, input int d, input int mn, input int y);
    c_hh = h; c_mi = m; c_ss = s; c_dd = d; c_mo = mn; c_yy = y;
    bus.cur_time = enc_t(h, m, s);
    bus.cur_date = enc_d(d, mn, y);
  endtask

  task automatic m_press(input bit i, input bit d, input bit c);
    int dl;
    dl = (i && !d) ? 1 : (d && !i) ? -1 : 0;
    if (mf == 0) begin
      if (c) begin
        hh = c_hh; mi = c_mi; ss = c_ss; dd = c_dd; mo = c_mo; yy = c_yy;
        mf = mode ? 4 : 1;
      end
    end else if (c) begin
      if (mf == 3) begin exp_lt++; exp_tv = enc_t(hh, mi, ss); mf = 0; end
      else if (mf == 6) begin exp_ld++; exp_dv = enc_d(dd, mo, yy); mf = 0; end
      else mf++;
    end else if (dl != 0) begin
      case (mf)
        1: hh = (hh + dl + 24) % 24;
        2: mi = (mi + dl + 60) % 60;
        3: ss = (ss + dl + 60) % 60;
        4: dd = (dd - 1 + dl + mdays(mo, yy)) % mdays(mo, yy) + 1;
        5: mo = (mo - 1 + dl + 12) % 12 + 1;
        default: yy = (yy + dl + 10000) % 10000;
      endcase
      if (mf >= 5 && dd > mdays(mo, yy)) dd = mdays(mo, yy);
    end
  endtask

  task automatic verify();
    chk("set_active", 32'(bus.set_active), 32'(mf != 0));
    chk("new_time", 32'(bus.new_time), 32'(enc_t(hh, mi, ss)));
    chk("new_date", bus.new_date, enc_d(dd, mo, yy));
    chk("load_time_count", nlt, exp_lt);
    chk("load_date_count", nld, exp_ld);
    chk("load_time_value", 32'(lt_val), 32'(exp_tv));
    chk("load_date_value", ld_val, exp_dv);
    if (mf == 0) chk("blink_idle", 32'(bus.blink_mask), 32'h0);
  endtask

  task automatic press(input bit i, input bit d, input bit c);
    @(negedge clk);
    bus.butt_increase = ~i;
    bus.butt_decrease = ~d;
    bus.butt_change   = ~c;
    repeat (DB + 6) @(negedge clk);
    bus.butt_increase = 1'b1;
    bus.butt_decrease = 1'b1;
    bus.butt_change   = 1'b1;
    repeat (DB + 6) @(negedge clk);
    m_press(i, d, c);
    verify();
  endtask

  task automatic toggle_mode();
    @(negedge clk);
    bus.sw_mode = ~bus.sw_mode;
    mode = bus.sw_mode;
    repeat (3) @(negedge clk);
    mf = 0;
    verify();
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_active"}, 32'(bus.set_active), 32'h0);
    chk({tag, "_load_time"}, 32'(bus.load_time), 32'h0);
    chk({tag, "_load_date"}, 32'(bus.load_date), 32'h0);
    chk({tag, "_new_time"}, 32'(bus.new_time), 32'h0);
    chk({tag, "_new_date"}, bus.new_date, 32'h0);
    chk({tag, "_blink"}, 32'(bus.blink_mask), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    reset_outputs("mid_reset");
    rst = 1'b0;
    mf = 0; hh = 0; mi = 0; ss = 0; dd = 0; mo = 0; yy = 0;
    repeat (20) @(negedge clk);
    verify();
  endtask

  initial begin
    int k, r;
    bit i, d, c;
    bus.butt_increase = 1'b1;
    bus.butt_decrease = 1'b1;
    bus.butt_change   = 1'b1;
    bus.sw_mode       = 1'b0;
    set_cur(12, 0, 0, 1, 1, 2000);
    repeat (3) @(negedge clk);
    reset_outputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // short glitch must be rejected
    bus.butt_change = 1'b0;
    repeat (3) @(negedge clk);
    bus.butt_change = 1'b1;
    repeat (DB + 8) @(negedge clk);
    chk("glitch_idle", 32'(bus.set_active), 32'h0);
    // long hold: one press into E_HOUR, then blink phase timing
    set_cur(23, 59, 58, 31, 3, 2024);
    @(negedge clk);
    bus.butt_change = 1'b0;
    for (k = 0; k < 20 && !bus.set_active; k++) @(negedge clk);
    chk("press_seen", 32'(bus.set_active), 32'h1);
    chk("blink_entry", 32'(bus.blink_mask), 32'hC0);
    repeat (BL - 1) @(negedge clk);
    chk("blink_before_toggle", 32'(bus.blink_mask), 32'hC0);
    @(negedge clk);
    chk("blink_off", 32'(bus.blink_mask), 32'h00);
    repeat (BL) @(negedge clk);
    chk("blink_on_again", 32'(bus.blink_mask), 32'hC0);
    bus.butt_change = 1'b1;
    repeat (DB + 6) @(negedge clk);
    m_press(1'b0, 1'b0, 1'b1);
    verify();
    // time wrap
    press(1, 0, 0);
    press(0, 0, 1);
    press(0, 1, 0);
    press(0, 0, 1);
    press(0, 0, 1);
    chk("time_wrap_value", 32'(lt_val), 32'h005858);
    // date clamp
    toggle_mode();
    press(0, 0, 1);
    press(0, 0, 1);
    press(1, 0, 0);
    chk("clamp_april", bus.new_date, 32'h30042024);
    repeat (10) press(1, 0, 0);
    chk("clamp_feb_leap", bus.new_date, 32'h29022024);
    press(0, 0, 1);
    press(1, 0, 0);
    chk("clamp_feb_2025", bus.new_date, 32'h28022025);
    press(0, 0, 1);
    chk("date_commit_value", ld_val, 32'h28022025);
    // century rule
    set_cur(0, 0, 0, 29, 2, 2096);
    press(0, 0, 1); press(0, 0, 1); press(0, 0, 1);
    repeat (4) press(1, 0, 0);
    chk("year_2100_clamp", bus.new_date, 32'h28022100);
    press(0, 0, 1);
    set_cur(0, 0, 0, 28, 2, 2100);
    press(0, 0, 1);
    press(1, 0, 0);
    chk("day_wrap_2100", bus.new_date, 32'h01022100);
    press(0, 0, 1); press(0, 0, 1); press(0, 0, 1);
    set_cur(0, 0, 0, 28, 2, 2000);
    press(0, 0, 1);
    press(1, 0, 0);
    chk("day_29_2000", bus.new_date, 32'h29022000);
    press(1, 0, 0);
    chk("day_wrap_2000", bus.new_date, 32'h01022000);
    press(0, 0, 1); press(0, 0, 1); press(0, 0, 1);
    // simultaneous presses and abort
    toggle_mode();
    set_cur(10, 20, 30, 1, 1, 2001);
    press(0, 0, 1);
    press(1, 0, 1);
    chk("change_beats_inc", 32'(bus.new_time), 32'h102030);
    press(1, 1, 0);
    chk("inc_dec_cancel", 32'(bus.new_time), 32'h102030);
    press(1, 0, 0);
    chk("minute_field", 32'(bus.new_time), 32'h102130);
    toggle_mode();
    chk("abort_idle", 32'(bus.set_active), 32'h0);
    // reset during E_DAY
    press(0, 0, 1);
    do_reset();
    // random traffic
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) toggle_mode();
      else if (r < 7) do_reset();
      else if (r < 15 && mf == 0) begin
        c_yy = int'($urandom_range(0, 9999));
        c_mo = int'($urandom_range(1, 12));
        set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)),
                int'($urandom_range(1, 28)) + int'($urandom_range(0, mdays(c_mo, c_yy) - 28)), c_mo, c_yy);
      end else begin
        c = ($urandom_range(0, 3) == 0);
        i = ($urandom_range(0, 1) == 1);
        d = ($urandom_range(0, 2) == 0);
        if (!c && !i && !d) i = 1'b1;
        press(i, d, c);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Front-panel editing controller for the decade clock/calendar: debounces the three pushbuttons, runs a field-select state machine, and edits a shadow copy of the time or date in BCD. On commit it pulses a load strobe with the new value so the counter reloads its digit registers. It also drives a per-digit blink mask so the display blanks the field being edited.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples required before accepting a button level (20 ms at 50 MHz)
- DB_W, 20: debounce counter width
- BLINK_CYCLES, 12_500_000: half-period of the edit blink
- BLINK_W, 24: blink counter width
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- butt_increase, butt_decrease, butt_change  in  1 each  raw pushbuttons, active-low, asynchronous to clk
- sw_mode  in  1  0 = time fields, 1 = date fields
- cur_time  in  24  {hour1,hour0,min1,min0,sec1,sec0} BCD from the counter
- cur_date  in  32  {day1,day0,month1,month0,year3,year2,year1,year0} BCD
- set_active  out  1  high while editing
- load_time, load_date  out  1  single-cycle commit strobes
- new_time  out  24, new_date  out  32  shadow values; valid in the load cycle and held afterwards
- blink_mask  out  8  bit i = 1 blanks display digit seg_i

## Operation
- Each button: 2-flop synchronizer, then a debouncer. The debouncer counts consecutive samples that differ from the accepted level and accepts the new level when the count reaches DEBOUNCE_CYCLES. Any sample equal to the accepted level clears the count. A 1->0 transition of the accepted level produces a one-cycle press pulse. Release produces nothing.
- States:
  - IDLE
  - time path: E_HOUR -> E_MIN -> E_SEC -> COMMIT
  - date path: E_DAY -> E_MONTH -> E_YEAR -> COMMIT
- IDLE + change press: copy cur_time/cur_date into the shadow registers, then enter E_HOUR (sw_mode=0) or E_DAY (sw_mode=1). Inc/dec presses in IDLE are ignored.
- Edit state + change press: advance to the next field. From the last field, go to COMMIT.
- COMMIT lasts one cycle. It asserts load_time (time path) or load_date (date path), then returns to IDLE.
- Inc/dec act on the current field in BCD with wrap-around:
  - hour 00..23
  - min/sec 00..59
  - month 01..12
  - year 0000..9999
  - day 01..max, where max = 31/30/28/29 by month
  - Leap year: divisible by 4 and (not divisible by 100, or divisible by 400).
- After every month or year edit, clamp day to the new max (e.g. 31 -> 30 entering April, 29 -> 28 leaving a leap year).
- Priority within a cycle: change press beats inc/dec (inc/dec dropped). Inc and dec pressed in the same cycle are both ignored.
- Any toggle of sw_mode while not in IDLE aborts the edit: return to IDLE with no load strobe.
- set_active = 1 in every state except IDLE.

## Timing
- Reset values:
  - state IDLE
  - all outputs 0
  - debounce accepted levels 1 (released), debounce counters 0
  - blink counter 0, blink phase 0
- Reset asserted mid-edit discards the shadow and produces no strobe.
- Press latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 from raw edge to press pulse.
- Field update is visible on new_time/new_date the cycle after the press pulse. State change also happens the cycle after the press pulse.
- COMMIT: the strobe is high for exactly one cycle. new_* are stable in that cycle and remain unchanged until the next IDLE->edit capture.
- Blink:
  - The counter runs only while set_active=1.
  - The phase toggles each BLINK_CYCLES.
  - blink_mask = field bits AND phase. Field bits: hour/day 8'hC0, min/month 8'h30, sec 8'h0C, year 8'h0F.
  - Entering a new field resets the counter and sets phase to 1 (field blanked immediately).
  - blink_mask is 0 in IDLE and COMMIT.
- At most one field step per press pulse; no auto-repeat.

## Test plan
(DEBOUNCE_CYCLES=4, BLINK_CYCLES=8 for all scenarios.)
- Debounce: 3-cycle low glitch on butt_change -> no press, state stays IDLE. Hold low for 10 cycles -> exactly one press pulse, state = E_HOUR, set_active=1, blink_mask=8'hC0.
- Time wrap: cur_time=23:59:58, sw_mode=0. Change, inc (hour->00), change, dec (min->58), change, change -> one load_time cycle with new_time=24'h005858, then state returns to IDLE.
- Date clamp: cur_date=31-03-2024, sw_mode=1. Change, change, inc (month->04) -> day=30. Inc ×10 (month->02) -> day=29. Change, inc (year->2025) -> day=28. Change -> load_date with new_date=32'h28022025.
- Century rule: edit year to 2100 with day=29, month=02 -> day clamps to 28. Edit year to 2000 -> day limit is 29; inc from 28 gives 29, next inc wraps to 01.
- Simultaneous events: change + inc in the same cycle -> field advances, value unchanged. Inc + dec in the same cycle -> no change.
- Abort: sw_mode toggle during E_MIN -> IDLE, no strobe. Reset pulse during E_DAY -> all outputs 0, no strobe after reset release.
